// File: rtl/ais_frame_crc.sv
// AIS receive-chain stage after the HDLC de-stuffer: packs bits LSB-first into
// bytes, runs the X.25 CRC-16 over the frame and reports length/FCS status at close.
module ais_frame_crc #(
  parameter int unsigned MAX_BYTES = 32,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF,
  parameter logic [15:0] CRC_GOOD  = 16'hF0B8
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_vld,
  input  logic       frm_start,
  input  logic       frm_end,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic [5:0] byte_cnt,
  output logic       frm_done,
  output logic       crc_ok,
  output logic       len_err
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE,
    DROP
  } state_t;

  localparam logic [5:0]  MAX_B = 6'(MAX_BYTES);
  localparam logic [15:0] POLY  = 16'h8408;

  state_t      state, state_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [2:0]  bit_cnt;
  logic [15:0] crc, crc_nxt, crc_close;
  logic [5:0]  cnt_nxt;
  logic        take_bit, byte_done, ovf, emit;
  logic        close_recv, close_drop, len_bad;
  logic        ok_q, len_q;

  // A coincident bit is folded in before the close decision, so every close
  // check looks at the post-bit counter/CRC values.
  always_comb begin
    take_bit   = (state == RECV) && bit_vld && !frm_start;
    byte_done  = take_bit && (bit_cnt == 3'd7);
    ovf        = byte_done && (byte_cnt == MAX_B);
    emit       = byte_done && !ovf;
    shreg_nxt  = {bit_in, shreg[7:1]};
    crc_nxt    = (crc >> 1) ^ ((crc[0] ^ bit_in) ? POLY : '0);
    crc_close  = take_bit ? crc_nxt : crc;
    cnt_nxt    = byte_cnt + {5'd0, emit};
    close_recv = (state == RECV) && frm_end && !frm_start;
    close_drop = (state == DROP) && frm_end && !frm_start;
    len_bad    = ovf
               || (take_bit ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0))
               || (cnt_nxt < 6'd3);
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (frm_start) state_nxt = RECV;
      RECV: begin
        if (frm_start)    state_nxt = RECV;
        else if (frm_end) state_nxt = DONE;
        else if (ovf)     state_nxt = DROP;
      end
      DONE: state_nxt = frm_start ? RECV : IDLE;
      DROP: begin
        if (frm_start)    state_nxt = RECV;
        else if (frm_end) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frm_done = (state == DONE);
    crc_ok   = (state == DONE) && ok_q;
    len_err  = (state == DONE) && len_q;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      crc      <= CRC_INIT;
      byte_out <= '0;
      byte_vld <= 1'b0;
      byte_cnt <= '0;
      ok_q     <= 1'b0;
      len_q    <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (frm_start) begin
        shreg    <= '0;
        bit_cnt  <= '0;
        crc      <= CRC_INIT;
        byte_cnt <= '0;
      end else if (take_bit) begin
        shreg   <= shreg_nxt;
        bit_cnt <= bit_cnt + 3'd1;
        crc     <= crc_nxt;
        if (emit) begin
          byte_out <= shreg_nxt;
          byte_vld <= 1'b1;
          byte_cnt <= cnt_nxt;
        end
      end
      if (close_recv) begin
        len_q <= len_bad;
        ok_q  <= (crc_close == CRC_GOOD) && !len_bad;
      end else if (close_drop) begin
        len_q <= 1'b1;
        ok_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ais_frame_crc.sv
// Randomized self-checking bench for ais_frame_crc; expectations come from a
// frame-level model (FCS built from payload, length rules applied to byte counts).
module tb_ais_frame_crc;

  typedef logic [7:0] bq_t[$];

  logic       sclk = 1'b0;
  logic       rst, bit_in, bit_vld, frm_start, frm_end;
  logic [7:0] byte_out;
  logic       byte_vld, frm_done, crc_ok, len_err;
  logic [5:0] byte_cnt;

  int vectors = 0, miscompares = 0;

  bq_t        rx_q;
  int         done_cnt = 0;
  logic       dn_ok, dn_len, dn_bv;
  logic [5:0] dn_cnt;

  always #5 sclk = ~sclk;

  ais_frame_crc #(
    .MAX_BYTES(32),
    .CRC_INIT (16'hFFFF),
    .CRC_GOOD (16'hF0B8)
  ) dut (
    .sclk     (sclk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .frm_start(frm_start),
    .frm_end  (frm_end),
    .byte_out (byte_out),
    .byte_vld (byte_vld),
    .byte_cnt (byte_cnt),
    .frm_done (frm_done),
    .crc_ok   (crc_ok),
    .len_err  (len_err)
  );

  always @(negedge sclk) begin
    if (byte_vld === 1'b1) rx_q.push_back(byte_out);
    if (frm_done === 1'b1) begin
      done_cnt++;
      dn_ok  = crc_ok;
      dn_len = len_err;
      dn_cnt = byte_cnt;
      dn_bv  = byte_vld;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1);
  end

  // Byte-at-a-time reflected CRC-16/X.25 register, no final inversion.
  function automatic logic [15:0] crc_reg(input bq_t d);
    logic [15:0] c = 16'hFFFF;
    foreach (d[i]) begin
      c = c ^ {8'd0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    logic [15:0] f = ~crc_reg(p);
    bq_t d = p;
    d.push_back(f[7:0]);
    d.push_back(f[15:8]);
    return d;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t d;
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    return d;
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Start pulse, data bits LSB-first (plus optional trailing partial byte), optional end.
  task automatic send_frame(input bq_t d, input int xbits, input logic [7:0] xval,
                            input bit coinc, input bit do_end, input int gap);
    bit bits[$];
    foreach (d[i]) for (int k = 0; k < 8; k++) bits.push_back(d[i][k]);
    for (int k = 0; k < xbits; k++) bits.push_back(xval[k]);
    frm_start = 1'b1; tick(); frm_start = 1'b0;
    foreach (bits[i]) begin
      bit_in  = bits[i];
      bit_vld = 1'b1;
      frm_end = coinc && do_end && (i == bits.size() - 1);
      tick();
      bit_vld = 1'b0;
      frm_end = 1'b0;
      repeat (gap) tick();
    end
    if (do_end && !(coinc && bits.size() > 0)) begin
      frm_end = 1'b1; tick(); frm_end = 1'b0;
    end
    if (do_end) repeat (3) tick();
  endtask

  task automatic test_reset();
    vectors++;
    if ({byte_out, byte_vld, byte_cnt, frm_done, crc_ok, len_err} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_held: got %h exp 0", {byte_out, byte_vld, byte_cnt, frm_done, crc_ok, len_err});
    end
    rst = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({byte_out, byte_vld, byte_cnt, frm_done, crc_ok, len_err} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %h exp 0", {byte_out, byte_vld, byte_cnt, frm_done, crc_ok, len_err});
    end
  endtask

  task automatic test_good();
    bq_t d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    int b0 = rx_q.size(), d0 = done_cnt;
    send_frame(d, 0, 8'h00, 1'b0, 1'b1, 1);
    vectors++;
    if (rx_q.size() - b0 != 11) begin
      miscompares++; $display("FAIL good_nbytes: got %0d exp 11", rx_q.size() - b0);
    end else foreach (d[i]) begin
      vectors++;
      if (rx_q[b0 + i] !== d[i]) begin
        miscompares++; $display("FAIL good_byte%0d: got %h exp %h", i, rx_q[b0 + i], d[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 != 1 || {dn_ok, dn_len} !== 2'b10 || dn_cnt !== 6'd11) begin
      miscompares++;
      $display("FAIL good_close: got done=%0d ok=%b len=%b cnt=%0d exp done=1 ok=1 len=0 cnt=11",
               done_cnt - d0, dn_ok, dn_len, dn_cnt);
    end
    vectors++;
    if (byte_cnt !== 6'd11) begin
      miscompares++; $display("FAIL good_cnt_hold: got %0d exp 11", byte_cnt);
    end
  endtask

  task automatic test_bad_fcs();
    bq_t d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h91};
    int d0 = done_cnt;
    send_frame(d, 0, 8'h00, 1'b0, 1'b1, 1);
    vectors++;
    if (done_cnt - d0 != 1 || {dn_ok, dn_len} !== 2'b00) begin
      miscompares++;
      $display("FAIL bad_fcs: got done=%0d ok=%b len=%b exp done=1 ok=0 len=0", done_cnt - d0, dn_ok, dn_len);
    end
  endtask

  task automatic test_latency();
    int d0 = done_cnt;
    send_frame('{}, 0, 8'h00, 1'b0, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      bit_in = k[0] ^ k[2];
      bit_vld = 1'b1; tick(); bit_vld = 1'b0;
    end
    vectors++;
    if ({byte_vld, byte_out, byte_cnt} !== {1'b1, 8'h5A, 6'd1}) begin
      miscompares++;
      $display("FAIL byte_latency: got vld=%b out=%h cnt=%0d exp vld=1 out=5a cnt=1", byte_vld, byte_out, byte_cnt);
    end
    tick();
    vectors++;
    if (byte_vld !== 1'b0) begin
      miscompares++; $display("FAIL byte_pulse: got %b exp 0", byte_vld);
    end
    frm_end = 1'b1; tick(); frm_end = 1'b0;
    vectors++;
    if ({frm_done, len_err, crc_ok} !== 3'b110) begin
      miscompares++; $display("FAIL done_latency: got done/len/ok=%b exp 110", {frm_done, len_err, crc_ok});
    end
    tick();
    vectors++;
    if (frm_done !== 1'b0 || byte_cnt !== 6'd1 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b cnt=%0d n=%0d exp 0 1 1", frm_done, byte_cnt, done_cnt - d0);
    end
  endtask

  task automatic test_misalign();
    bq_t d = rand_bytes(8);
    int b0 = rx_q.size(), d0 = done_cnt;
    send_frame(d, 3, 8'($urandom), 1'b0, 1'b1, 0);
    vectors++;
    if (rx_q.size() - b0 != 8 || rx_q[b0 + 7] !== d[7]) begin
      miscompares++; $display("FAIL misalign_bytes: got %0d exp 8", rx_q.size() - b0);
    end
    vectors++;
    if (done_cnt - d0 != 1 || {dn_ok, dn_len} !== 2'b01) begin
      miscompares++;
      $display("FAIL misalign_close: got done=%0d ok=%b len=%b exp 1 0 1", done_cnt - d0, dn_ok, dn_len);
    end
  endtask

  task automatic test_overflow();
    bq_t d = rand_bytes(40);
    int b0 = rx_q.size(), d0 = done_cnt;
    send_frame(d, 0, 8'h00, 1'b0, 1'b0, 0);
    repeat (2) tick();
    vectors++;
    if (rx_q.size() - b0 != 32 || byte_cnt !== 6'd32 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL ovf_before_end: got bytes=%0d cnt=%0d done=%0d exp 32 32 0",
               rx_q.size() - b0, byte_cnt, done_cnt - d0);
    end
    vectors++;
    if (rx_q[b0 + 31] !== d[31]) begin
      miscompares++; $display("FAIL ovf_last_byte: got %h exp %h", rx_q[b0 + 31], d[31]);
    end
    frm_end = 1'b1; tick(); frm_end = 1'b0;
    repeat (2) tick();
    vectors++;
    if (done_cnt - d0 != 1 || {dn_ok, dn_len} !== 2'b01 || dn_cnt !== 6'd32) begin
      miscompares++;
      $display("FAIL ovf_close: got done=%0d ok=%b len=%b cnt=%0d exp 1 0 1 32", done_cnt - d0, dn_ok, dn_len, dn_cnt);
    end
  endtask

  task automatic test_coincident();
    bq_t d = with_fcs(rand_bytes(9));
    int d0 = done_cnt;
    send_frame(d, 0, 8'h00, 1'b1, 1'b1, 0);
    vectors++;
    if (done_cnt - d0 != 1 || {dn_bv, dn_ok, dn_len} !== 3'b110 || dn_cnt !== 6'd11) begin
      miscompares++;
      $display("FAIL coincident: got done=%0d bv=%b ok=%b len=%b cnt=%0d exp 1 1 1 0 11",
               done_cnt - d0, dn_bv, dn_ok, dn_len, dn_cnt);
    end
  endtask

  task automatic test_restart();
    bq_t d = with_fcs(rand_bytes(4));
    int d0 = done_cnt;
    send_frame(rand_bytes(5), 0, 8'h00, 1'b0, 1'b0, 0);
    tick();
    frm_start = 1'b1; tick(); frm_start = 1'b0;
    repeat (3) tick();
    vectors++;
    if (byte_cnt !== 6'd0 || done_cnt != d0) begin
      miscompares++; $display("FAIL restart_clear: got cnt=%0d done=%0d exp 0 0", byte_cnt, done_cnt - d0);
    end
    send_frame(d, 0, 8'h00, 1'b0, 1'b1, 1);
    vectors++;
    if (done_cnt - d0 != 1 || {dn_ok, dn_len} !== 2'b10 || dn_cnt !== 6'd6) begin
      miscompares++;
      $display("FAIL restart_frame: got done=%0d ok=%b len=%b cnt=%0d exp 1 1 0 6", done_cnt - d0, dn_ok, dn_len, dn_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bq_t d = with_fcs(rand_bytes(21));
    int b0, d0 = done_cnt;
    send_frame(rand_bytes(5), 0, 8'h00, 1'b0, 1'b0, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if ({byte_out, byte_vld, byte_cnt, frm_done, crc_ok, len_err} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h exp 0", {byte_out, byte_vld, byte_cnt, frm_done, crc_ok, len_err});
    end
    tick(); rst = 1'b0; tick();
    b0 = rx_q.size();
    for (int i = 0; i < 16; i++) begin
      bit_in = 1'($urandom); bit_vld = 1'b1; tick(); bit_vld = 1'b0;
    end
    frm_end = 1'b1; tick(); frm_end = 1'b0;
    repeat (3) tick();
    vectors++;
    if (rx_q.size() != b0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL post_reset_ignore: got bytes=%0d done=%0d exp 0 0", rx_q.size() - b0, done_cnt - d0);
    end
    send_frame(d, 0, 8'h00, 1'b0, 1'b1, 0);
    vectors++;
    if (done_cnt - d0 != 1 || {dn_ok, dn_len} !== 2'b10 || dn_cnt !== 6'd23) begin
      miscompares++;
      $display("FAIL ais_frame: got done=%0d ok=%b len=%b cnt=%0d exp 1 1 0 23", done_cnt - d0, dn_ok, dn_len, dn_cnt);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      bq_t d = with_fcs(rand_bytes($urandom_range(0, 34)));
      bit corrupt = ($urandom_range(0, 3) == 0);
      int xbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      bit coinc = 1'($urandom);
      int nb, n_emit, b0 = rx_q.size(), d0 = done_cnt;
      bit exp_len, exp_ok, data_ok = 1'b1;
      if (corrupt) begin
        int idx = $urandom_range(0, d.size() - 1);
        d[idx] = d[idx] ^ (8'd1 << $urandom_range(0, 7));
      end
      nb      = d.size();
      n_emit  = (nb > 32) ? 32 : nb;
      exp_len = (xbits != 0) || (nb < 3) || (nb > 32);
      exp_ok  = !exp_len && !corrupt;
      send_frame(d, xbits, 8'($urandom), coinc, 1'b1, $urandom_range(0, 2));
      vectors++;
      if (rx_q.size() - b0 != n_emit) begin
        miscompares++;
        $display("FAIL rand%0d_nbytes: got %0d exp %0d", f, rx_q.size() - b0, n_emit);
      end else begin
        for (int i = 0; i < n_emit; i++) if (rx_q[b0 + i] !== d[i]) data_ok = 1'b0;
        vectors++;
        if (!data_ok) begin
          miscompares++; $display("FAIL rand%0d_data: got byte stream differs exp sent bytes", f);
        end
      end
      vectors++;
      if (done_cnt - d0 != 1 || {dn_ok, dn_len} !== {exp_ok, exp_len} || dn_cnt !== 6'(n_emit)) begin
        miscompares++;
        $display("FAIL rand%0d_close: got done=%0d ok=%b len=%b cnt=%0d exp 1 %b %b %0d",
                 f, done_cnt - d0, dn_ok, dn_len, dn_cnt, exp_ok, exp_len, n_emit);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_vld = 1'b0; frm_start = 1'b0; frm_end = 1'b0;
    repeat (2) tick();
    test_reset();
    test_good();
    test_bad_fcs();
    test_latency();
    test_misalign();
    test_overflow();
    test_coincident();
    test_restart();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ais_frame_crc.md
Name: ais_frame_crc

Overview:
- Stage directly downstream of the HDLC de-framer/de-stuffer in the AIS receive chain.
- Consumes the de-stuffed bit stream plus frame start/end strobes and packs the bits LSB-first into bytes.
- Runs the HDLC CRC-16 (X.25) over the whole frame and, at frame close, reports length and FCS validity.
- Nominal AIS message: 168 payload bits + 16 FCS bits = 184 bits = 23 bytes.

Parameters:
- MAX_BYTES, 32, frame length limit in bytes including the 2 FCS bytes; must be ≤ 63.
- CRC_INIT, 16'hFFFF, CRC register preset at frame start.
- CRC_GOOD, 16'hF0B8, CRC register residue after a correct data+FCS frame.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- bit_in  in  1  de-stuffed data bit; meaningful only when bit_vld=1.
- bit_vld  in  1  one-cycle strobe per accepted data bit (stuffed zeros never strobed).
- frm_start  in  1  one-cycle pulse; opening flag detected.
- frm_end  in  1  one-cycle pulse; closing flag detected.
- byte_out  out  8  assembled byte; first received bit in bit 0.
- byte_vld  out  1  one-cycle strobe qualifying byte_out.
- byte_cnt  out  6  bytes emitted in the current or last frame.
- frm_done  out  1  one-cycle pulse at frame close; qualifies crc_ok and len_err.
- crc_ok  out  1  1 = CRC residue equals CRC_GOOD and len_err=0.
- len_err  out  1  1 = frame not byte-aligned, shorter than 3 bytes, or longer than MAX_BYTES.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register 0; bit counter 0; CRC = CRC_INIT.
- FSM states and transitions:
  - IDLE: frm_start → RECV. bit_vld and frm_end are ignored.
  - RECV: on frm_start, clear counters, preset CRC, stay in RECV; the partial frame is aborted with no frm_done. On frm_end → DONE. On overflow → DROP.
  - DONE: lasts one cycle. Asserts frm_done, crc_ok and len_err, then returns to IDLE. A frm_start in this cycle goes directly to RECV.
  - DROP: ignores bits until frm_end. Then emits frm_done with len_err=1 and crc_ok=0, and returns to IDLE. frm_start in DROP → RECV.
- CRC update, per bit_vld in RECV:
  - fb = crc[0] ^ bit_in
  - crc = (crc >> 1) ^ (fb ? 16'h8408 : 0)
  - The CRC runs over all bits, including the FCS bits.
- Byte packing:
  - Shift right, with bit_in entering bit 7.
  - On the 8th bit, byte_out is registered and byte_vld pulses one cycle after that bit's bit_vld.
  - byte_cnt increments in the same cycle as byte_vld.
- Overflow: a byte completing when byte_cnt == MAX_BYTES is not emitted and the FSM enters DROP.
- Simultaneous bit_vld and frm_end in RECV:
  - The bit is processed first, so CRC and packing include it.
  - A byte completed by that bit has byte_vld in the same cycle as frm_done.
- Alignment: len_err=1 if the bit counter ≠ 0 at frm_end, or if byte_cnt < 3.
- crc_ok = (crc == CRC_GOOD) && !len_err, sampled at frm_end including the coincident bit.
- byte_cnt holds its value after frm_done until the next frm_start, which clears it.
- frm_start and frm_end in the same cycle in RECV: frm_start wins, giving a restart with no frm_done.
- Reset mid-frame returns to IDLE immediately with no pulses. Bytes received after reset are ignored until the next frm_start.
- Latency: byte_vld and frm_done are each 1 cycle after their causing input strobe.

Test Plan:
- Good frame: frm_start; bytes 0x31..0x39 ("123456789") LSB-first, then FCS 0x6E, 0x90, with 1-cycle gaps between bit_vld; frm_end.
  - Expect 11 byte_vld pulses with byte_out 0x31..0x39, 0x6E, 0x90.
  - Expect frm_done=1, crc_ok=1, len_err=0, byte_cnt=11.
- Corrupted FCS: same frame with the last byte sent as 0x91 → frm_done=1, crc_ok=0, len_err=0.
- Misalignment: 8 bytes plus 3 extra bits, then frm_end → 8 byte_vld pulses, frm_done=1, len_err=1, crc_ok=0.
- Overflow (MAX_BYTES=32): 40 bytes then frm_end.
  - Expect exactly 32 byte_vld pulses, byte_cnt=32.
  - Expect frm_done only at frm_end, with len_err=1.
- Coincident events:
  - Last FCS bit presented in the same cycle as frm_end → byte_vld and frm_done in the same cycle, crc_ok=1.
  - frm_start issued mid-frame → no frm_done, byte_cnt restarts from 0.
- Reset: assert rst after 5 bytes → all outputs 0 at once. Then a 184-bit valid AIS frame → byte_cnt=23, crc_ok=1.
